// File: rtl/image_cell_alu.sv
// image_cell_alu: multi-cycle, lane-parallel per-channel saturating
// arithmetic on DIM x DIM pixel cells with valid/ready in and out.
module image_cell_alu #(
   parameter int DIM      = 4,
   parameter int CHANNELS = 3,
   parameter int CH_WIDTH = 8,
   parameter int LANES    = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [2:0]                         opcode,
   input  logic [DIM*DIM*CHANNELS*CH_WIDTH-1:0] cellA,
   input  logic [DIM*DIM*CHANNELS*CH_WIDTH-1:0] cellB,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [DIM*DIM*CHANNELS*CH_WIDTH-1:0] result,
   output logic                               sat
);

   localparam int NPIX   = DIM * DIM;
   localparam int PIX_W  = CHANNELS * CH_WIDTH;
   localparam int CELL_W = NPIX * PIX_W;
   localparam int BEATS  = NPIX / LANES;
   localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0] OP_ADD   = 3'd0;
   localparam logic [2:0] OP_SUB   = 3'd1;
   localparam logic [2:0] OP_AVG   = 3'd2;
   localparam logic [2:0] OP_MAX   = 3'd3;
   localparam logic [2:0] OP_MIN   = 3'd4;
   localparam logic [2:0] OP_INV   = 3'd5;
   localparam logic [2:0] OP_PASSA = 3'd6;
   localparam logic [2:0] OP_PASSB = 3'd7;

   logic [1:0]        state;
   logic [CW-1:0]     cnt;
   logic [2:0]        op_q;
   logic [CELL_W-1:0] a_q;
   logic [CELL_W-1:0] b_q;
   logic [CELL_W-1:0] res_q;
   logic              sat_q;
   logic              ov_q;

   logic [PIX_W-1:0]  lane_pix [LANES];
   logic              beat_sat;
   logic [CH_WIDTH:0] ch_r;
   int                base;

   // Returns {clamped, value} for one channel.
   function automatic logic [CH_WIDTH:0] alu_ch(
      input logic [2:0]          op,
      input logic [CH_WIDTH-1:0] a,
      input logic [CH_WIDTH-1:0] b
   );
      logic [CH_WIDTH:0] sum;
      logic [CH_WIDTH:0] r;
      sum = {1'b0, a} + {1'b0, b};
      r   = '0;
      unique case (op)
         OP_ADD:   r = sum[CH_WIDTH] ? {1'b1, {CH_WIDTH{1'b1}}} : sum;
         OP_SUB:   r = (a < b) ? {1'b1, {CH_WIDTH{1'b0}}} : {1'b0, a - b};
         OP_AVG:   r = {1'b0, sum[CH_WIDTH:1]};
         OP_MAX:   r = {1'b0, (a > b) ? a : b};
         OP_MIN:   r = {1'b0, (a < b) ? a : b};
         OP_INV:   r = {1'b0, ~a};
         OP_PASSA: r = {1'b0, a};
         OP_PASSB: r = {1'b0, b};
         default:  r = '0;
      endcase
      return r;
   endfunction

   assign base = 32'(cnt) * LANES;

   always_comb begin
      beat_sat = 1'b0;
      ch_r     = '0;
      for (int l = 0; l < LANES; l++) begin
         lane_pix[l] = '0;
         for (int c = 0; c < CHANNELS; c++) begin
            ch_r = alu_ch(op_q,
               a_q[(base + l) * PIX_W + c * CH_WIDTH +: CH_WIDTH],
               b_q[(base + l) * PIX_W + c * CH_WIDTH +: CH_WIDTH]);
            lane_pix[l][c * CH_WIDTH +: CH_WIDTH] = ch_r[CH_WIDTH-1:0];
            beat_sat = beat_sat | ch_r[CH_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         res_q <= '0;
         sat_q <= 1'b0;
         ov_q  <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (in_valid) begin
                  op_q  <= opcode;
                  a_q   <= cellA;
                  b_q   <= cellB;
                  res_q <= '0;
                  sat_q <= 1'b0;
                  cnt   <= '0;
                  state <= S_BUSY;
               end
            end
            S_BUSY: begin
               for (int l = 0; l < LANES; l++)
                  res_q[(base + l) * PIX_W +: PIX_W] <= lane_pix[l];
               sat_q <= sat_q | beat_sat;
               if (cnt == CW'(BEATS - 1)) begin
                  cnt   <= '0;
                  ov_q  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  ov_q  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Reset gating keeps in_ready low while reset is held.
   assign in_ready  = (state == S_IDLE) && !reset;
   assign out_valid = ov_q;
   assign result    = res_q;
   assign sat       = sat_q;

endmodule

// File: tb/tb_image_cell_alu.sv
// tb_image_cell_alu: randomized and directed scoreboard bench
// for image_cell_alu against an integer per-channel model.
module tb_image_cell_alu;

   localparam int DIM    = 4;
   localparam int CH     = 3;
   localparam int CHW    = 8;
   localparam int LANES  = 4;
   localparam int NPIX   = DIM * DIM;
   localparam int PIX_W  = CH * CHW;
   localparam int CELL_W = NPIX * PIX_W;
   localparam int BEATS  = NPIX / LANES;
   localparam int MAXV   = (1 << CHW) - 1;

   typedef logic [CELL_W-1:0] cell_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [2:0] opcode = '0;
   cell_t      cellA = '0;
   cell_t      cellB = '0;
   logic       out_valid;
   logic       out_ready;
   cell_t      result;
   logic       sat;

   logic rand_bp = 1'b0;
   logic rnd_ready = 1'b1;
   logic or_force = 1'b1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_hs = -1;
   int last_acc = -1;
   logic ov_prev = 1'b0;

   logic [CELL_W:0] sb_q [$];
   int              lat_q [$];

   assign out_ready = rand_bp ? rnd_ready : or_force;

   image_cell_alu #(
      .DIM(DIM), .CHANNELS(CH), .CH_WIDTH(CHW), .LANES(LANES)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .cellA(cellA), .cellB(cellB),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .sat(sat)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      #1 rnd_ready = 1'($urandom_range(0, 1));
   end

   task automatic chk(input string nm, input cell_t act, input cell_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chkb(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b want %b", nm, act, exp);
      end
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   function automatic cell_t fill(input logic [PIX_W-1:0] px);
      cell_t c;
      for (int p = 0; p < NPIX; p++) c[p * PIX_W +: PIX_W] = px;
      return c;
   endfunction

   function automatic cell_t rnd_cell();
      cell_t c;
      for (int i = 0; i < CELL_W / 32; i++) c[i * 32 +: 32] = $urandom;
      return c;
   endfunction

   // Integer reference: each channel computed from the opcode rules.
   task automatic model(input int op, input cell_t a, input cell_t b,
                        output cell_t r, output logic s);
      int x;
      int y;
      int v;
      r = '0;
      s = 1'b0;
      for (int p = 0; p < NPIX; p++) begin
         for (int c = 0; c < CH; c++) begin
            x = int'(a[p * PIX_W + c * CHW +: CHW]);
            y = int'(b[p * PIX_W + c * CHW +: CHW]);
            case (op)
               0: begin v = x + y; if (v > MAXV) begin v = MAXV; s = 1'b1; end end
               1: begin v = x - y; if (v < 0) begin v = 0; s = 1'b1; end end
               2: v = (x + y) / 2;
               3: v = (x > y) ? x : y;
               4: v = (x < y) ? x : y;
               5: v = MAXV - x;
               6: v = x;
               default: v = y;
            endcase
            r[p * PIX_W + c * CHW +: CHW] = CHW'(v);
         end
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         ov_prev = 1'b0;
      end else begin
         if (out_valid && !ov_prev) begin
            if (lat_q.size() == 0) begin
               chkb("unexpected_out_valid", out_valid, 1'b0);
            end else begin
               chki("latency_cycle", cyc, lat_q.pop_front());
            end
         end
         if (out_valid && out_ready) begin
            last_hs = cyc + 1;
            if (sb_q.size() == 0) begin
               chkb("unexpected_handshake", out_valid, 1'b0);
            end else begin
               logic [CELL_W:0] e;
               e = sb_q.pop_front();
               chk("result", result, e[CELL_W-1:0]);
               chkb("sat", sat, e[CELL_W]);
            end
         end
         ov_prev = out_valid;
      end
   end

   task automatic issue(input logic [2:0] op, input cell_t a, input cell_t b);
      cell_t r;
      logic  s;
      int    n;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      opcode = op;
      cellA = a;
      cellB = b;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 60) begin
            chkb("accept_timeout", in_ready, 1'b1);
            in_valid = 1'b0;
            return;
         end
      end
      model(int'(op), a, b, r, s);
      sb_q.push_back({s, r});
      lat_q.push_back(cyc + 1 + BEATS);
      last_acc = cyc + 1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      opcode = 3'($urandom);
      cellA = rnd_cell();
      cellB = rnd_cell();
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chki("drain_pending", sb_q.size(), 0);
      @(negedge clk);
   endtask

   initial begin
      cell_t ramp;
      cell_t e1;
      logic  s1;
      int    n;

      #3;
      chkb("rst_in_ready", in_ready, 1'b0);
      chkb("rst_out_valid", out_valid, 1'b0);
      chk("rst_result", result, '0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chkb("post_rst_in_ready", in_ready, 1'b1);

      issue(3'd0, fill(24'h000000), fill(24'h00FF00));
      for (int p = 0; p < NPIX; p++) ramp[p * PIX_W +: PIX_W] = PIX_W'(p * 24'h010101);
      issue(3'd0, ramp, '0);
      issue(3'd0, fill(24'h00FF00), fill(24'h00FF00));
      issue(3'd0, fill(24'hFF0000), fill(24'h0000FF));
      issue(3'd1, fill(24'h000000), fill(24'hFFFFFF));
      issue(3'd2, fill(24'hFFFFFF), fill(24'h000000));
      issue(3'd5, fill(24'hFF0000), rnd_cell());
      issue(3'd3, fill(24'h123456), fill(24'h654321));
      issue(3'd4, fill(24'h123456), fill(24'h654321));
      issue(3'd7, rnd_cell(), rnd_cell());
      issue(3'd6, rnd_cell(), rnd_cell());
      wait_idle();

      // Backpressure with a second instruction pending.
      or_force = 1'b0;
      model(0, fill(24'h00FF00), fill(24'h00FF00), e1, s1);
      issue(3'd0, fill(24'h00FF00), fill(24'h00FF00));
      n = 0;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chkb("bp_out_valid", out_valid, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b1;
         opcode = 3'd3;
         cellA = fill(24'h123456);
         cellB = fill(24'h654321);
         @(negedge clk);
         chkb("bp_in_ready", in_ready, 1'b0);
         chkb("bp_valid_hold", out_valid, 1'b1);
         chk("bp_result_hold", result, e1);
         chkb("bp_sat_hold", sat, s1);
      end
      @(posedge clk);
      #1;
      or_force = 1'b1;
      issue(3'd3, fill(24'h123456), fill(24'h654321));
      chki("bp_accept_after_hs", last_acc, last_hs + 1);
      wait_idle();

      // Reset in the middle of BUSY discards the transaction.
      issue(3'd0, rnd_cell(), rnd_cell());
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b1;
      sb_q.delete();
      lat_q.delete();
      #1;
      chkb("mid_rst_out_valid", out_valid, 1'b0);
      chk("mid_rst_result", result, '0);
      chkb("mid_rst_sat", sat, 1'b0);
      chkb("mid_rst_in_ready", in_ready, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chkb("mid_rst_release_ready", in_ready, 1'b1);
      repeat (10) @(negedge clk);
      issue(3'd0, fill(24'h00FF00), fill(24'h0000FF));
      wait_idle();

      rand_bp = 1'b1;
      for (int i = 0; i < 40; i++)
         issue(3'($urandom_range(0, 7)), rnd_cell(), rnd_cell());
      wait_idle();
      rand_bp = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
